// File: rtl/delay_buffer_2d_pkg.sv
// Shared elaboration-time checks for the 2-D delay buffer.
// No types live here: the element type stays local to each module.
package delay_buffer_2d_pkg;

    function automatic bit params_ok(
        input int delay,
        input int num_features,
        input int n,
        input int precision
    );
        return (delay >= 32'sd0) && (num_features >= 32'sd1) &&
               (n >= 32'sd1) && (precision >= 32'sd1);
    endfunction

endpackage

// File: rtl/delay_buffer.sv
// Scalar PRECISION-bit delay line of DELAY stages.
// DELAY = 0 is a plain wire; otherwise an async-cleared shift chain.
module delay_buffer
    import delay_buffer_2d_pkg::*;
#(
    parameter int PRECISION = 4,
    parameter int DELAY     = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PRECISION-1:0] d,
    output logic [PRECISION-1:0] q
);

    generate
        if (DELAY == 0) begin : g_pass
            // clk and rst_n are intentionally unused in pass-through mode
            logic unused_s;
            assign unused_s = clk ^ rst_n;
            assign q        = d;
        end else begin : g_pipe
            logic [PRECISION-1:0] stage_r [DELAY];

            // Shift chain: stage 0 captures d, the last stage drives q
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < DELAY; k++) begin
                        stage_r[k] <= '0;
                    end
                end else begin
                    stage_r[0] <= d;
                    for (int k = 1; k < DELAY; k++) begin
                        stage_r[k] <= stage_r[k-1];
                    end
                end
            end

            assign q = stage_r[DELAY-1];
        end
    endgenerate

endmodule

// File: rtl/delay_buffer_2d.sv
// NUM_FEATURES x N array of independent PRECISION-bit delay lines.
// Element positions are preserved; each element is an opaque bit vector.
module delay_buffer_2d
    import delay_buffer_2d_pkg::*;
#(
    parameter int NUM_FEATURES = 4,
    parameter int N            = 4,
    parameter int PRECISION    = 4,
    parameter int DELAY        = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PRECISION-1:0] idata [NUM_FEATURES-1:0][N-1:0],
    output logic [PRECISION-1:0] odata [NUM_FEATURES-1:0][N-1:0]
);

    generate
        if (!params_ok(DELAY, NUM_FEATURES, N, PRECISION)) begin : g_bad_params
            $error("delay_buffer_2d: illegal parameters DELAY=%0d NUM_FEATURES=%0d N=%0d PRECISION=%0d",
                   DELAY, NUM_FEATURES, N, PRECISION);
        end

        for (genvar f = 0; f < NUM_FEATURES; f++) begin : g_feat
            for (genvar i = 0; i < N; i++) begin : g_elem
                delay_buffer #(
                    .PRECISION (PRECISION),
                    .DELAY     (DELAY)
                ) u_buf (
                    .clk   (clk),
                    .rst_n (rst_n),
                    .d     (idata[f][i]),
                    .q     (odata[f][i])
                );
            end
        end
    endgenerate

endmodule

// File: tb/tb_delay_buffer_2d.sv
// Self-checking bench: DELAY 0/1/3 on a 4x4x4 array plus a 2x3x8 DELAY=2
// index-mapping instance, checked against a history-queue reference model.
module tb_delay_buffer_2d;

    logic clk;
    logic rst_n;

    logic [3:0] in44 [3:0][3:0];
    logic [3:0] o0   [3:0][3:0];
    logic [3:0] o1   [3:0][3:0];
    logic [3:0] o3   [3:0][3:0];
    logic [7:0] inm  [1:0][2:0];
    logic [7:0] om   [1:0][2:0];

    // Inputs sampled on each rising edge since the last reset release
    logic [63:0] q44 [$];
    logic [47:0] qm  [$];

    int total = 0;
    int bad   = 0;

    delay_buffer_2d #(.NUM_FEATURES(4), .N(4), .PRECISION(4), .DELAY(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .idata(in44), .odata(o0));
    delay_buffer_2d #(.NUM_FEATURES(4), .N(4), .PRECISION(4), .DELAY(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .idata(in44), .odata(o1));
    delay_buffer_2d #(.NUM_FEATURES(4), .N(4), .PRECISION(4), .DELAY(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .idata(in44), .odata(o3));
    delay_buffer_2d #(.NUM_FEATURES(2), .N(3), .PRECISION(8), .DELAY(2)) u_map (
        .clk(clk), .rst_n(rst_n), .idata(inm), .odata(om));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pack44(input logic [3:0] a [3:0][3:0]);
        logic [63:0] r;
        r = 64'h0;
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < 4; i++)
                r[(f*4+i)*4 +: 4] = a[f][i];
        return r;
    endfunction

    function automatic logic [47:0] packm(input logic [7:0] a [1:0][2:0]);
        logic [47:0] r;
        r = 48'h0;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 3; i++)
                r[(f*3+i)*8 +: 8] = a[f][i];
        return r;
    endfunction

    // Output after edge n is the input sampled at edge n-D+1, or 0 if that predates reset release
    function automatic logic [63:0] exp44(input int d);
        if (d == 0) return pack44(in44);
        if (q44.size() >= d) return q44[q44.size()-d];
        return 64'h0;
    endfunction

    function automatic logic [47:0] expm(input int d);
        if (qm.size() >= d) return qm[qm.size()-d];
        return 48'h0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("d0_out", pack44(o0), exp44(0));
        chk("d1_out", pack44(o1), exp44(1));
        chk("d3_out", pack44(o3), exp44(3));
        chk("map_out", {16'h0, packm(om)}, {16'h0, expm(2)});
    endtask

    task automatic set_vec(input int k);
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < 4; i++)
                in44[f][i] = 4'((4*f + i + 1 + k) % 16);
        #1;
        chk("d0_comb", pack44(o0), pack44(in44));
    endtask

    task automatic set_map();
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 3; i++)
                inm[f][i] = 8'(16*f + i);
    endtask

    task automatic set_rand();
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < 4; i++)
                in44[f][i] = 4'($urandom_range(15));
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 3; i++)
                inm[f][i] = 8'($urandom_range(255));
        #1;
        chk("d0_comb_rand", pack44(o0), pack44(in44));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) begin
            q44.push_back(pack44(in44));
            qm.push_back(packm(inm));
        end
        #1;
        check_all();
    endtask

    // Reset pulse placed between clock edges; in-flight data is discarded
    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        q44.delete();
        qm.delete();
        #1;
        check_all();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        set_map();
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < 4; i++)
                in44[f][i] = 4'((4*f + i + 1) % 16);
        #1;
        rst_n = 1'b0;
        #1;
        check_all();
        #10;
        rst_n = 1'b1;

        // v0..v3 on successive edges, then hold so DELAY=3 drains
        for (int k = 0; k < 4; k++) begin
            set_vec(k);
            step();
        end
        for (int k = 0; k < 3; k++) step();

        // v0, v1, reset mid-flight, then v2, v3: v0/v1 must never appear
        pulse_reset();
        set_vec(0);
        step();
        set_vec(1);
        step();
        pulse_reset();
        set_vec(2);
        step();
        set_vec(3);
        step();
        for (int k = 0; k < 3; k++) step();

        // Randomized traffic with one reset in the middle
        for (int s = 0; s < 60; s++) begin
            set_rand();
            step();
            if (s == 25) pulse_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/delay_buffer_2d.md
DELAY_BUFFER_2D -- requirements
Module: delay_buffer_2d

Interface
REQ-001 SHALL have parameter NUM_FEATURES, default 4: outer array dimension (rows).
REQ-002 SHALL have parameter N, default 4: inner array dimension (elements per row).
REQ-003 SHALL have parameter PRECISION, default 4: bit width of each element.
REQ-004 SHALL have parameter DELAY, default 0: latency in clock cycles, 0 = combinational pass-through.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk, rst_n.
REQ-006 clk  input  1  rising-edge clock for all storage.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 idata  input  unpacked [NUM_FEATURES-1:0][N-1:0] of PRECISION bits  data written every cycle.
REQ-009 odata  output  unpacked [NUM_FEATURES-1:0][N-1:0] of PRECISION bits  idata delayed by DELAY cycles.

Function
REQ-010 SHALL, for DELAY = 0, drive odata[f][i] = idata[f][i] combinationally for every f, i; no registers inferred; rst_n has no effect.
REQ-011 SHALL, for DELAY >= 1, implement a DELAY-stage shift pipeline per element: odata at posedge k+DELAY equals idata sampled at posedge k.
REQ-012 SHALL shift every cycle unconditionally; no enable, no valid, no stall.
REQ-013 SHALL preserve element positions: no reordering across f or i indices.
REQ-014 SHALL treat elements as opaque bit vectors; no arithmetic, sign handling or truncation.
REQ-015 SHALL produce 0 on odata during the first DELAY cycles after reset release until real data propagates.
REQ-016 SHALL reject DELAY < 0, NUM_FEATURES < 1, N < 1, PRECISION < 1 with an elaboration-time error.
REQ-017 SHALL propagate X/unknown inputs unchanged (no masking) in simulation.

Reset
REQ-018 SHALL, while rst_n = 0 and DELAY >= 1, force all pipeline stages and odata to 0 immediately, independent of clk.
REQ-019 SHALL, on rst_n deassertion, resume shifting on the next rising clk edge; data captured before reset is lost.
REQ-020 SHALL discard in-flight data when reset is asserted mid-operation; no partial outputs after release.

Structure
REQ-021 SHALL keep parameter checks and no types in a shared package; element type is local (logic [PRECISION-1:0]).
REQ-022 SHALL use one sub-module delay_buffer (scalar PRECISION-bit, DELAY-stage, same clk/rst_n semantics), instantiated NUM_FEATURES x N times via nested generate loops.
REQ-023 SHALL select pass-through vs. register chain inside delay_buffer with a generate on DELAY == 0.

Verification
REQ-024 DELAY=0: apply {{1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,0}} -> odata equal same cycle; next vector {{2,3,4,5},...} -> follows immediately.
REQ-025 DELAY=1: apply vectors v0={{1,2,3,4},...}, v1={{2,3,4,5},...}, v2, v3 on successive edges -> odata = v0 after one edge, v1 after next, etc.; odata 0 before first capture.
REQ-026 DELAY=3: same four vectors -> odata 0 for edges 1-2 after first capture, then v0, v1, v2, v3 on consecutive cycles.
REQ-027 DELAY=3: assert rst_n low between clock edges after v1 captured -> odata 0 at once; after release, v2 input appears 3 edges later, v0/v1 never appear.
REQ-028 Index mapping: NUM_FEATURES=2, N=3, PRECISION=8, DELAY=2, idata[f][i] = 16*f+i -> odata[f][i] identical per index after 2 edges.
REQ-029 Elaborate with DELAY=-1 -> elaboration error reported.
